z16_fetch_unit: RTL

Instruction-fetch front end of the Z16 core. Holds the program counter, drives the address of the combinational instruction memory, and captures each returned 16-bit instruction with its PC into a 2-entry queue. The decoder drains the queue through a valid/ready handshake. The execute stage redirects fetch on taken branches and jumps, which flushes everything queued.

---
 rtl/z16_fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/z16_fetch_unit.sv
// Z16 instruction-fetch front end: PC register, combinational imem address,
// and a 2-entry {instr, pc} queue drained by the decoder over valid/ready.
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  localparam int unsigned XW    = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic [XW-1:0] pc_q, pc_n;
  logic [XW-1:0] qi_q [DEPTH];
  logic [XW-1:0] qi_n [DEPTH];
  logic [XW-1:0] qp_q [DEPTH];
  logic [XW-1:0] qp_n [DEPTH];
  logic [CW-1:0] count_q, count_n;
  logic          head_q, head_n;
  logic          tail_q, tail_n;
  logic          valid_q, valid_n;
  logic [XW-1:0] instr_q, instr_n;
  logic [XW-1:0] opc_q, opc_n;
  logic          pop_c;
  logic          push_c;

  // Bit 0 of the redirect target is architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = i_redirect_pc[0];

  // Redirect suppresses both queue ports; a full queue blocks fetch even on pop.
  assign pop_c  = valid_q & i_ready & ~i_redirect;
  assign push_c = i_enable & ~i_redirect & (count_q < CW'(DEPTH));

  // Next-state: queue, pointers, PC and the registered head view.
  always_comb begin
    pc_n    = pc_q;
    qi_n    = qi_q;
    qp_n    = qp_q;
    count_n = count_q;
    head_n  = head_q;
    tail_n  = tail_q;

    if (i_redirect) begin
      pc_n    = {i_redirect_pc[XW-1:1], 1'b0};
      count_n = '0;
      head_n  = 1'b0;
      tail_n  = 1'b0;
    end else begin
      if (push_c) begin
        qi_n[tail_q] = i_imem_instr;
        qp_n[tail_q] = pc_q;
        tail_n       = ~tail_q;
        pc_n         = pc_q + XW'(2);
      end
      if (pop_c) begin
        head_n = ~head_q;
      end
      count_n = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Head outputs track the next head entry; they hold while the queue is empty.
    valid_n = (count_n != '0);
    instr_n = instr_q;
    opc_n   = opc_q;
    if (valid_n) begin
      instr_n = qi_n[head_n];
      opc_n   = qp_n[head_n];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        qi_q[i] <= '0;
        qp_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_n;
      count_q <= count_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      opc_q   <= opc_n;
      for (int i = 0; i < int'(DEPTH); i++) begin
        qi_q[i] <= qi_n[i];
        qp_q[i] <= qp_n[i];
      end
    end
  end

  assign o_imem_addr = pc_q;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;

endmodule
